// File: rtl/magma_pkg.sv
// rtl/magma_pkg.sv - Magma cipher constants, S-box, state type and key schedule helper
package magma_pkg;

  localparam int ROUNDS = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Row i is the substitution applied to nibble i (bits [4i+3:4i]) of the round input.
  localparam logic [3:0] SBOX [8][16] = '{
    '{4'hc, 4'h4, 4'h6, 4'h2, 4'ha, 4'h5, 4'hb, 4'h9, 4'he, 4'h8, 4'hd, 4'h7, 4'h0, 4'h3, 4'hf, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'ha, 4'h5, 4'hc, 4'h1, 4'he, 4'h4, 4'h7, 4'hb, 4'hd, 4'h0, 4'hf},
    '{4'hb, 4'h3, 4'h5, 4'h8, 4'h2, 4'hf, 4'ha, 4'hd, 4'he, 4'h1, 4'h7, 4'h4, 4'hc, 4'h9, 4'h6, 4'h0},
    '{4'hc, 4'h8, 4'h2, 4'h1, 4'hd, 4'h4, 4'hf, 4'h6, 4'h7, 4'h0, 4'ha, 4'h5, 4'h3, 4'he, 4'h9, 4'hb},
    '{4'h7, 4'hf, 4'h5, 4'ha, 4'h8, 4'h1, 4'h6, 4'hd, 4'h0, 4'h9, 4'h3, 4'he, 4'hb, 4'h4, 4'h2, 4'hc},
    '{4'h5, 4'hd, 4'hf, 4'h6, 4'h9, 4'h2, 4'hc, 4'ha, 4'hb, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'he, 4'h0},
    '{4'h8, 4'he, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hc, 4'hf, 4'h4, 4'hb, 4'h0, 4'hd, 4'ha, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'he, 4'hd, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hf, 4'ha, 4'h6, 4'h9, 4'hc, 4'hb, 4'h2}
  };

  // Index 0..7 selects K1..K8; the descending runs use 7 - (r mod 8), i.e. the bitwise inverse.
  function automatic logic [2:0] round_key_idx(input logic [4:0] round, input logic decrypt);
    if (decrypt) begin
      return (round < 5'd8) ? round[2:0] : ~round[2:0];
    end
    return (round < 5'd24) ? round[2:0] : ~round[2:0];
  endfunction

endpackage

// File: rtl/magma_round.sv
// rtl/magma_round.sv - combinational single Magma Feistel round for one 64-bit lane
module magma_round
  import magma_pkg::*;
(
  input  logic [31:0] a1_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] rk_i,
  input  logic        last_i,
  output logic [31:0] a1_o,
  output logic [31:0] a0_o
);

  logic [31:0] t;
  logic [31:0] s;
  logic [31:0] g;

  assign t = a0_i + rk_i;

  always_comb begin
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[4*i +: 4] = SBOX[i][t[4*i +: 4]];
    end
  end

  assign g = {s[20:0], s[31:21]};

  // The final round leaves the halves unswapped so the output is directly {a1^g, a0}.
  always_comb begin
    if (last_i) begin
      a1_o = a1_i ^ g;
      a0_o = a0_i;
    end else begin
      a1_o = a0_i;
      a0_o = a1_i ^ g;
    end
  end

endmodule

// File: rtl/magma_core.sv
// rtl/magma_core.sv - iterative two-lane ECB Magma engine, one round per clock
module magma_core
  import magma_pkg::*;
(
  input  logic         clk,
  input  logic         reset_,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] data_in,
  input  logic [255:0] key,
  output logic [127:0] data_out,
  output logic         done,
  output logic         busy
);

  state_e             state_q, state_d;
  logic [4:0]         round_q, round_d;
  logic               start_q;
  logic               dec_q, dec_d;
  logic [255:0]       key_q, key_d;
  logic [1:0][31:0]   a1_q, a1_d, a0_q, a0_d;
  logic [1:0][31:0]   nx_a1, nx_a0;
  logic [127:0]       out_q, out_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic [2:0]         rk_idx;
  logic [31:0]        rk;
  logic               last;
  logic               accept;

  assign rk_idx = round_key_idx(round_q, dec_q);
  assign rk     = key_q[{~rk_idx, 5'b0} +: 32];
  assign last   = (round_q == 5'(ROUNDS - 1));
  assign accept = start && !start_q && (state_q != BUSY);

  magma_round u_round_l0 (
    .a1_i(a1_q[0]), .a0_i(a0_q[0]), .rk_i(rk), .last_i(last),
    .a1_o(nx_a1[0]), .a0_o(nx_a0[0])
  );

  magma_round u_round_l1 (
    .a1_i(a1_q[1]), .a0_i(a0_q[1]), .rk_i(rk), .last_i(last),
    .a1_o(nx_a1[1]), .a0_o(nx_a0[1])
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    dec_d   = dec_q;
    key_d   = key_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    out_d   = out_q;
    done_d  = done_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = BUSY;
          round_d = '0;
          dec_d   = decrypt;
          key_d   = key;
          a1_d[1] = data_in[127:96];
          a0_d[1] = data_in[95:64];
          a1_d[0] = data_in[63:32];
          a0_d[0] = data_in[31:0];
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        a1_d    = nx_a1;
        a0_d    = nx_a0;
        round_d = round_q + 5'd1;
        if (last) begin
          state_d = DONE;
          out_d   = {nx_a1[1], nx_a0[1], nx_a1[0], nx_a0[0]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      round_q <= '0;
      start_q <= 1'b0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      a1_q    <= '0;
      a0_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      start_q <= start;
      dec_q   <= dec_d;
      key_q   <= key_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out = out_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_magma_core.sv
// tb/tb_magma_core.sv - self-checking bench for magma_core against a behavioural Magma model
module tb_magma_core;

  logic         clk = 1'b0;
  logic         reset_;
  logic         start;
  logic         decrypt;
  logic [127:0] data_in;
  logic [255:0] key;
  logic [127:0] data_out;
  logic         done;
  logic         busy;

  int checks = 0;
  int failures = 0;

  magma_core dut (
    .clk(clk), .reset_(reset_), .start(start), .decrypt(decrypt),
    .data_in(data_in), .key(key), .data_out(data_out), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] PI [8][16] = '{
    '{4'hc, 4'h4, 4'h6, 4'h2, 4'ha, 4'h5, 4'hb, 4'h9, 4'he, 4'h8, 4'hd, 4'h7, 4'h0, 4'h3, 4'hf, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'ha, 4'h5, 4'hc, 4'h1, 4'he, 4'h4, 4'h7, 4'hb, 4'hd, 4'h0, 4'hf},
    '{4'hb, 4'h3, 4'h5, 4'h8, 4'h2, 4'hf, 4'ha, 4'hd, 4'he, 4'h1, 4'h7, 4'h4, 4'hc, 4'h9, 4'h6, 4'h0},
    '{4'hc, 4'h8, 4'h2, 4'h1, 4'hd, 4'h4, 4'hf, 4'h6, 4'h7, 4'h0, 4'ha, 4'h5, 4'h3, 4'he, 4'h9, 4'hb},
    '{4'h7, 4'hf, 4'h5, 4'ha, 4'h8, 4'h1, 4'h6, 4'hd, 4'h0, 4'h9, 4'h3, 4'he, 4'hb, 4'h4, 4'h2, 4'hc},
    '{4'h5, 4'hd, 4'hf, 4'h6, 4'h9, 4'h2, 4'hc, 4'ha, 4'hb, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'he, 4'h0},
    '{4'h8, 4'he, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hc, 4'hf, 4'h4, 4'hb, 4'h0, 4'hd, 4'ha, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'he, 4'hd, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hf, 4'ha, 4'h6, 4'h9, 4'hc, 4'hb, 4'h2}
  };

  localparam logic [255:0] STD_KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  STD_PT  = 64'hfedcba9876543210;
  localparam logic [63:0]  STD_CT  = 64'h4ee901e5c2d8ca3d;

  // Decryption uses the encryption key schedule read backwards.
  function automatic logic [63:0] ref_block(logic [255:0] k, logic [63:0] b, logic dec);
    logic [31:0] kk [8];
    int          enc_sched [32];
    int          sched [32];
    logic [31:0] a1, a0, t, s, g;
    for (int i = 0; i < 8; i++) kk[i] = k[255 - 32*i -: 32];
    for (int r = 0; r < 32; r++) enc_sched[r] = (r < 24) ? (r % 8) : (31 - r);
    for (int r = 0; r < 32; r++) sched[r] = dec ? enc_sched[31 - r] : enc_sched[r];
    a1 = b[63:32];
    a0 = b[31:0];
    for (int r = 0; r < 32; r++) begin
      t = a0 + kk[sched[r]];
      for (int n = 0; n < 8; n++) s[4*n +: 4] = PI[n][t[4*n +: 4]];
      g = (s << 11) | (s >> 21);
      if (r < 31) begin
        t  = a1 ^ g;
        a1 = a0;
        a0 = t;
      end else begin
        a1 = a1 ^ g;
      end
    end
    return {a1, a0};
  endfunction

  function automatic logic [127:0] ref_word(logic [255:0] k, logic [127:0] d, logic dec);
    return {ref_block(k, d[127:64], dec), ref_block(k, d[63:0], dec)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One full request; inputs are scrambled while busy to show the captured copies are used.
  task automatic do_op(input logic [255:0] k, input logic [127:0] d, input logic dec,
                       output logic [127:0] res);
    int bad;
    bad = 0;
    @(negedge clk);
    key = k; data_in = d; decrypt = dec; start = 1'b1;
    @(posedge clk); #1;
    if (busy !== 1'b1 || done !== 1'b0) bad++;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      start = 1'b0;
      key = rand_key(); data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      decrypt = $urandom_range(0, 1);
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    if (busy !== 1'b0 || done !== 1'b1) bad++;
    chk("op_timing", 128'(bad), 128'd0);
    res = data_out;
  endtask

  typedef struct {
    logic [255:0] k;
    logic [127:0] d;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [3];
  logic [127:0] res, res2, rd, da, db;
  logic [255:0] rk;
  int           busy_cnt, rises, n;
  logic         prev_done, got;

  initial begin
    reset_ = 1'b0; start = 1'b0; decrypt = 1'b0; data_in = '0; key = '0;

    vecs[0] = '{STD_KEY, {STD_PT, STD_PT}, 1'b0, {STD_CT, STD_CT}};
    vecs[1] = '{STD_KEY, {STD_CT, 64'd0}, 1'b1, {STD_PT, ref_block(STD_KEY, 64'd0, 1'b1)}};
    vecs[2] = '{STD_KEY, {64'd0, STD_PT}, 1'b0, {ref_block(STD_KEY, 64'd0, 1'b0), STD_CT}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {data_out[127:2], done, busy}, 128'd0);
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", {data_out[127:2], done, busy}, 128'd0);

    for (int i = 0; i < 3; i++) begin
      do_op(vecs[i].k, vecs[i].d, vecs[i].dec, res);
      chk($sformatf("vector_%0d", i), res, vecs[i].exp);
    end

    // Held-high start: one operation only.
    @(negedge clk);
    key = STD_KEY; data_in = {STD_CT, STD_PT}; decrypt = 1'b0; start = 1'b1;
    busy_cnt = 0; rises = 0; prev_done = done;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      busy_cnt += int'(busy);
      if (done && !prev_done) rises++;
      prev_done = done;
    end
    chk("held_busy_cycles", 128'(busy_cnt), 128'd32);
    chk("held_done_rises", 128'(rises), 128'd1);
    chk("held_done_level", 128'(done), 128'd1);
    chk("held_result", data_out, ref_word(STD_KEY, {STD_CT, STD_PT}, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;

    // Start edge during BUSY at round 10 is ignored.
    rk = rand_key();
    da = {$urandom(), $urandom(), $urandom(), $urandom()};
    db = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    key = rk; data_in = da; decrypt = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    got = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      start = (i >= 11 && i < 14);
      if (i == 11) data_in = db;
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        n = i;
      end
    end
    chk("ignored_start_latency", 128'(n), 128'd32);
    chk("ignored_start_result", data_out, ref_word(rk, da, 1'b0));
    do_op(rk, db, 1'b0, res);
    chk("after_done_result", res, ref_word(rk, db, 1'b0));

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    key = rk; data_in = da; decrypt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset_ = 1'b0;
    #1;
    chk("midreset_outputs", {data_out[127:2], done, busy}, 128'd0);
    chk("midreset_data_low", 128'(data_out[1:0]), 128'd0);
    @(negedge clk);
    reset_ = 1'b1;
    do_op(rk, da, 1'b1, res);
    chk("post_reset_result", res, ref_word(rk, da, 1'b1));

    for (int it = 0; it < 250; it++) begin
      rk = rand_key();
      da = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_op(rk, da, 1'b0, res);
      chk("rand_encrypt", res, ref_word(rk, da, 1'b0));
      rd = ref_word(rk, res, 1'b1);
      do_op(rk, res, 1'b1, res2);
      chk("rand_decrypt", res2, rd);
      chk("rand_round_trip", res2, da);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
